// File: rtl/module_registro_datos_spi_multi.sv
// Two-port SPI register bank: control word at address 0, data words above it,
// byte-enabled host writes and an engine-side receive stream with count/overflow.
module module_registro_datos_spi_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 2,
    parameter int WRAP_EN    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr1_i,
    input  logic [ADDR_W-1:0]       addr1_i,
    input  logic [DATA_WIDTH/8-1:0] be1_i,
    input  logic [DATA_WIDTH-1:0]   data_in1_i,
    output logic [DATA_WIDTH-1:0]   data1_o,
    input  logic                    hold_ctrl_i,
    input  logic                    wr2_i,
    input  logic [ADDR_W-1:0]       addr2_i,
    input  logic [DATA_WIDTH-1:0]   data_in2_i,
    output logic [DATA_WIDTH-1:0]   data2_o,
    input  logic                    push2_i,
    input  logic                    ptr_clr_i,
    output logic [ADDR_W-1:0]       ptr_o,
    output logic [ADDR_W-1:0]       cnt_o,
    output logic                    ovf_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_WIDTH / 8;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data1_q, data2_q;
    logic [ADDR_W-1:0]     ptr_q, ptr_d, cnt_q, cnt_d, ptr_nxt;
    logic                  ovf_q, ovf_d;
    logic                  full;
    logic                  p2_we;
    logic [ADDR_W-1:0]     p2_addr;

    assign full    = (cnt_q == TOP_ADDR);
    assign ptr_nxt = (ptr_q == TOP_ADDR) ? ADDR_W'(1) : ptr_q + ADDR_W'(1);

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        p2_we   = 1'b0;
        p2_addr = addr2_i;

        if (ptr_clr_i) begin
            ptr_d = ADDR_W'(1);
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (push2_i) begin
            if (!full) begin
                p2_we   = 1'b1;
                p2_addr = ptr_q;
                cnt_d   = cnt_q + ADDR_W'(1);
                ptr_d   = ptr_nxt;
            end else begin
                ovf_d = 1'b1;
                if (WRAP_EN != 0) begin
                    p2_we   = 1'b1;
                    p2_addr = ptr_q;
                    ptr_d   = ptr_nxt;
                end
            end
        end

        // A push owns port 2 for the cycle, even when it is itself dropped.
        if (!push2_i && wr2_i && (addr2_i != '0)) begin
            p2_we   = 1'b1;
            p2_addr = addr2_i;
        end

        if (wr1_i && ((addr1_i != '0) || !hold_ctrl_i)) begin
            for (int k = 0; k < NB; k++) begin
                if (be1_i[k]) begin
                    mem_d[addr1_i][8*k +: 8] = data_in1_i[8*k +: 8];
                end
            end
        end

        // Applied last so port 2 wins the whole word on an address collision.
        if (p2_we) begin
            mem_d[p2_addr] = data_in2_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data1_q <= '0;
            data2_q <= '0;
            ptr_q   <= ADDR_W'(1);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            data1_q <= mem_q[addr1_i];
            data2_q <= mem_q[addr2_i];
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data1_o = data1_q;
    assign data2_o = data2_q;
    assign ptr_o   = ptr_q;
    assign cnt_o   = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_module_registro_datos_spi_multi.sv
// Bench for the SPI register bank: a wrapping and a non-wrapping instance share
// stimulus and are compared every cycle against an array-based reference model.
module tb_module_registro_datos_spi_multi;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, wr1_i, hold_ctrl_i, wr2_i, push2_i, ptr_clr_i;
    logic [AW-1:0] addr1_i, addr2_i;
    logic [3:0]    be1_i;
    logic [DW-1:0] data_in1_i, data_in2_i;

    logic [DW-1:0] d1_a, d2_a, d1_b, d2_b;
    logic [AW-1:0] ptr_a, cnt_a, ptr_b, cnt_b;
    logic          ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;

    // index 0: wrapping instance, index 1: stop-when-full instance
    logic [DW-1:0] m_mem [2][DEPTH];
    logic [DW-1:0] m_d1 [2];
    logic [DW-1:0] m_d2 [2];
    int            m_ptr [2];
    int            m_cnt [2];
    int            m_ovf [2];

    always #5 clk_i = ~clk_i;

    module_registro_datos_spi_multi #(.DATA_WIDTH(DW), .ADDR_W(AW), .WRAP_EN(1)) u_dut_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .wr1_i(wr1_i), .addr1_i(addr1_i), .be1_i(be1_i),
        .data_in1_i(data_in1_i), .data1_o(d1_a), .hold_ctrl_i(hold_ctrl_i),
        .wr2_i(wr2_i), .addr2_i(addr2_i), .data_in2_i(data_in2_i), .data2_o(d2_a),
        .push2_i(push2_i), .ptr_clr_i(ptr_clr_i), .ptr_o(ptr_a), .cnt_o(cnt_a), .ovf_o(ovf_a)
    );

    module_registro_datos_spi_multi #(.DATA_WIDTH(DW), .ADDR_W(AW), .WRAP_EN(0)) u_dut_stop (
        .clk_i(clk_i), .rst_i(rst_i), .wr1_i(wr1_i), .addr1_i(addr1_i), .be1_i(be1_i),
        .data_in1_i(data_in1_i), .data1_o(d1_b), .hold_ctrl_i(hold_ctrl_i),
        .wr2_i(wr2_i), .addr2_i(addr2_i), .data_in2_i(data_in2_i), .data2_o(d2_b),
        .push2_i(push2_i), .ptr_clr_i(ptr_clr_i), .ptr_o(ptr_b), .cnt_o(cnt_b), .ovf_o(ovf_b)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst_i = 1'b1; wr1_i = 1'b0; hold_ctrl_i = 1'b0; wr2_i = 1'b0;
        push2_i = 1'b0; ptr_clr_i = 1'b0; be1_i = 4'h0;
        data_in1_i = '0; data_in2_i = '0;
    endtask

    // Next model state from the inputs present before the coming edge.
    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            logic [DW-1:0] nd1, nd2;
            nd1 = m_mem[w][addr1_i];
            nd2 = m_mem[w][addr2_i];
            if (!rst_i) begin
                for (int i = 0; i < DEPTH; i++) m_mem[w][i] = '0;
                m_d1[w] = '0; m_d2[w] = '0;
                m_ptr[w] = 1; m_cnt[w] = 0; m_ovf[w] = 0;
            end else begin
                m_d1[w] = nd1;
                m_d2[w] = nd2;
                if (wr1_i && (addr1_i != 0 || !hold_ctrl_i))
                    for (int k = 0; k < 4; k++)
                        if (be1_i[k]) m_mem[w][addr1_i][8*k +: 8] = data_in1_i[8*k +: 8];
                if (ptr_clr_i) begin
                    m_ptr[w] = 1; m_cnt[w] = 0; m_ovf[w] = 0;
                end else if (push2_i) begin
                    if (m_cnt[w] < DEPTH - 1) begin
                        m_mem[w][m_ptr[w]] = data_in2_i;
                        m_cnt[w] = m_cnt[w] + 1;
                        m_ptr[w] = (m_ptr[w] % (DEPTH - 1)) + 1;
                    end else begin
                        m_ovf[w] = 1;
                        if (w == 0) begin
                            m_mem[w][m_ptr[w]] = data_in2_i;
                            m_ptr[w] = (m_ptr[w] % (DEPTH - 1)) + 1;
                        end
                    end
                end
                if (!push2_i && wr2_i && addr2_i != 0) m_mem[w][addr2_i] = data_in2_i;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_i);
        #1;
        check_val("d1_wrap",  d1_a,       m_d1[0]);
        check_val("d2_wrap",  d2_a,       m_d2[0]);
        check_val("ptr_wrap", DW'(ptr_a), DW'(m_ptr[0]));
        check_val("cnt_wrap", DW'(cnt_a), DW'(m_cnt[0]));
        check_val("ovf_wrap", DW'(ovf_a), DW'(m_ovf[0]));
        check_val("d1_stop",  d1_b,       m_d1[1]);
        check_val("d2_stop",  d2_b,       m_d2[1]);
        check_val("ptr_stop", DW'(ptr_b), DW'(m_ptr[1]));
        check_val("cnt_stop", DW'(cnt_b), DW'(m_cnt[1]));
        check_val("ovf_stop", DW'(ovf_b), DW'(m_ovf[1]));
    endtask

    task automatic push(input logic [DW-1:0] d);
        idle(); push2_i = 1'b1; data_in2_i = d; cyc();
    endtask

    initial begin
        idle();
        addr1_i = '0; addr2_i = '0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < DEPTH; i++) m_mem[w][i] = 'x;
            m_d1[w] = 'x; m_d2[w] = 'x;
        end
        @(negedge clk_i);

        // reset and defaults
        rst_i = 1'b0; model_step(); @(posedge clk_i); #1;
        rst_i = 1'b0; cyc();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            addr1_i = AW'(a); addr2_i = AW'(DEPTH - 1 - a); cyc();
            check_val("rst_read1", d1_a, 32'h0);
            check_val("rst_read2", d2_b, 32'h0);
        end
        check_val("rst_ptr", DW'(ptr_a), 32'd1);

        // byte enables and control hold
        idle(); wr1_i = 1; addr1_i = 0; data_in1_i = 32'h11223344; be1_i = 4'hF; cyc();
        idle(); wr1_i = 1; data_in1_i = 32'hAABBCCDD; be1_i = 4'h5; cyc();
        idle(); addr1_i = 0; cyc();
        check_val("be_merge", d1_a, 32'h11BB33DD);
        idle(); wr1_i = 1; data_in1_i = 32'hFFFFFFFF; be1_i = 4'hF; hold_ctrl_i = 1; cyc();
        idle(); cyc(); cyc();
        check_val("ctrl_hold", d1_a, 32'h11BB33DD);

        // engine random access, address 0 protected
        idle(); wr2_i = 1; addr2_i = 1; data_in2_i = 32'h12; cyc();
        idle(); wr2_i = 1; addr2_i = 0; data_in2_i = 32'h99; cyc();
        idle(); addr1_i = 1; cyc();
        check_val("p2_write", d1_a, 32'h12);
        addr1_i = 0; cyc();
        check_val("p2_ctrl_prot", d1_b, 32'h11BB33DD);

        // stream fill on both instances
        idle(); ptr_clr_i = 1; cyc();
        push(32'hA1); push(32'hA2); push(32'hA3);
        check_val("fill_cnt", DW'(cnt_a), 32'd3);
        check_val("fill_ptr", DW'(ptr_a), 32'd1);
        push(32'hA4);
        check_val("wrap_ovf", DW'(ovf_a), 32'd1);
        check_val("wrap_ptr", DW'(ptr_a), 32'd2);
        check_val("stop_ovf", DW'(ovf_b), 32'd1);
        check_val("stop_ptr", DW'(ptr_b), 32'd1);
        idle(); addr1_i = 1; cyc(); cyc();
        check_val("wrap_mem1", d1_a, 32'hA4);
        check_val("stop_mem1", d1_b, 32'hA1);

        // simultaneous events
        idle(); ptr_clr_i = 1; cyc();
        idle(); push2_i = 1; wr2_i = 1; addr2_i = 3; data_in2_i = 32'h55; cyc();
        idle(); addr1_i = 1; addr2_i = 3; cyc(); cyc();
        check_val("push_vs_wr2", d1_a, 32'h55);
        idle(); wr1_i = 1; addr1_i = 2; be1_i = 4'hF; data_in1_i = 32'hDEAD0001;
        wr2_i = 1; addr2_i = 2; data_in2_i = 32'hBEEF0002; cyc();
        idle(); addr1_i = 2; cyc(); cyc();
        check_val("collision", d1_a, 32'hBEEF0002);
        idle(); ptr_clr_i = 1; push2_i = 1; data_in2_i = 32'h77; cyc();
        check_val("clr_push_cnt", DW'(cnt_a), 32'd0);
        idle(); addr1_i = 1; cyc(); cyc();
        check_val("clr_push_mem", d1_a, 32'h55);

        // reset mid-stream
        push(32'hC1); push(32'hC2);
        idle(); rst_i = 0; cyc();
        idle(); addr1_i = 1; addr2_i = 2; cyc(); cyc();
        check_val("rst_mid_d1", d1_a, 32'h0);
        check_val("rst_mid_cnt", DW'(cnt_a), 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_i       = ($urandom_range(63) != 0);
            wr1_i       = $urandom_range(1);
            addr1_i     = AW'($urandom_range(DEPTH - 1));
            be1_i       = 4'($urandom_range(15));
            data_in1_i  = $urandom;
            hold_ctrl_i = ($urandom_range(3) == 0);
            wr2_i       = $urandom_range(1);
            addr2_i     = AW'($urandom_range(DEPTH - 1));
            data_in2_i  = $urandom;
            push2_i     = ($urandom_range(2) == 0);
            ptr_clr_i   = ($urandom_range(15) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
